// File: rtl/ddr_port_arbiter.sv
// Two-port round-robin arbiter that sequences one read/write burst at a time into ddr_sdram.
// Grant, strobe and fields appear one cycle after REQ is sampled; BUSY stalls it; done pulses after BUSY falls.
module ddr_port_arbiter #(
   parameter int BURST_LENGTH  = 16,
   parameter int ISSUE_TIMEOUT = 16
) (
   input  logic                      SYS_CLK_100M,
   input  logic                      RST_N,
   input  logic                      P0_REQ,
   input  logic                      P0_WR,
   input  logic [1:0]                P0_BA,
   input  logic [12:0]               P0_ROW,
   input  logic [9:0]                P0_COL,
   input  logic [16*BURST_LENGTH-1:0] P0_DATA,
   input  logic [3:0]                P0_LEN,
   output logic                      P0_GNT,
   output logic                      P0_DONE,
   input  logic                      P1_REQ,
   input  logic                      P1_WR,
   input  logic [1:0]                P1_BA,
   input  logic [12:0]               P1_ROW,
   input  logic [9:0]                P1_COL,
   input  logic [16*BURST_LENGTH-1:0] P1_DATA,
   input  logic [3:0]                P1_LEN,
   output logic                      P1_GNT,
   output logic                      P1_DONE,
   output logic [1:0]                BA_IN,
   output logic [12:0]               ADDR_ROW_IN,
   output logic [9:0]                ADDR_COL_IN,
   output logic [16*BURST_LENGTH-1:0] DATA_IN,
   output logic [3:0]                WRITE_LENGTH,
   output logic                      WRITE,
   output logic                      READ,
   input  logic                      BUSY,
   output logic                      TIMEOUT_ERR
);

   localparam logic [7:0] TO_LIM = 8'(ISSUE_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t     state;
   logic       owner;
   logic       last;
   logic [7:0] cnt;
   logic       any_req;
   logic       win;
   logic       win_wr;

   // On contention the port that did not win last time goes next.
   always_comb begin
      any_req = P0_REQ | P1_REQ;
      win     = (P0_REQ && P1_REQ) ? ~last : P1_REQ;
      win_wr  = win ? P1_WR : P0_WR;
   end

   always_ff @(posedge SYS_CLK_100M or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last         <= 1'b1;
         cnt          <= 8'd0;
         P0_GNT       <= 1'b0;
         P1_GNT       <= 1'b0;
         P0_DONE      <= 1'b0;
         P1_DONE      <= 1'b0;
         BA_IN        <= '0;
         ADDR_ROW_IN  <= '0;
         ADDR_COL_IN  <= '0;
         DATA_IN      <= '0;
         WRITE_LENGTH <= '0;
         WRITE        <= 1'b0;
         READ         <= 1'b0;
         TIMEOUT_ERR  <= 1'b0;
      end else begin
         P0_GNT  <= 1'b0;
         P1_GNT  <= 1'b0;
         P0_DONE <= 1'b0;
         P1_DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (!BUSY && any_req) begin
                  BA_IN        <= win ? P1_BA   : P0_BA;
                  ADDR_ROW_IN  <= win ? P1_ROW  : P0_ROW;
                  ADDR_COL_IN  <= win ? P1_COL  : P0_COL;
                  DATA_IN      <= win ? P1_DATA : P0_DATA;
                  WRITE_LENGTH <= win ? P1_LEN  : P0_LEN;
                  WRITE        <= win_wr;
                  READ         <= ~win_wr;
                  P0_GNT       <= ~win;
                  P1_GNT       <= win;
                  owner        <= win;
                  last         <= win;
                  cnt          <= 8'd0;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               if (BUSY) begin
                  WRITE <= 1'b0;
                  READ  <= 1'b0;
                  state <= WAIT;
               end else if (cnt >= TO_LIM) begin
                  // Controller never accepted the command: give the port its done anyway.
                  WRITE       <= 1'b0;
                  READ        <= 1'b0;
                  TIMEOUT_ERR <= 1'b1;
                  P0_DONE     <= ~owner;
                  P1_DONE     <= owner;
                  state       <= IDLE;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            WAIT: begin
               if (!BUSY) begin
                  P0_DONE <= ~owner;
                  P1_DONE <= owner;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: a transaction-level model is compared every cycle,
// plus literal expectations per scenario; a small responder plays the ddr_sdram BUSY side.
module tb_ddr_port_arbiter;
   localparam int BL = 16;
   localparam int DW = 16*BL;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic RST_N = 1'b0;
   logic P0_REQ = 0, P0_WR = 0, P1_REQ = 0, P1_WR = 0;
   logic [1:0] P0_BA = 0, P1_BA = 0;
   logic [12:0] P0_ROW = 0, P1_ROW = 0;
   logic [9:0] P0_COL = 0, P1_COL = 0;
   logic [DW-1:0] P0_DATA = 0, P1_DATA = 0;
   logic [3:0] P0_LEN = 0, P1_LEN = 0;
   logic BUSY = 1'b0;
   logic P0_GNT, P0_DONE, P1_GNT, P1_DONE, WRITE, READ, TIMEOUT_ERR;
   logic [1:0] BA_IN;
   logic [12:0] ADDR_ROW_IN;
   logic [9:0] ADDR_COL_IN;
   logic [DW-1:0] DATA_IN;
   logic [3:0] WRITE_LENGTH;

   always #5 clk = ~clk;

   ddr_port_arbiter #(.BURST_LENGTH(BL), .ISSUE_TIMEOUT(TO)) dut (
      .SYS_CLK_100M(clk), .RST_N(RST_N),
      .P0_REQ(P0_REQ), .P0_WR(P0_WR), .P0_BA(P0_BA), .P0_ROW(P0_ROW), .P0_COL(P0_COL),
      .P0_DATA(P0_DATA), .P0_LEN(P0_LEN), .P0_GNT(P0_GNT), .P0_DONE(P0_DONE),
      .P1_REQ(P1_REQ), .P1_WR(P1_WR), .P1_BA(P1_BA), .P1_ROW(P1_ROW), .P1_COL(P1_COL),
      .P1_DATA(P1_DATA), .P1_LEN(P1_LEN), .P1_GNT(P1_GNT), .P1_DONE(P1_DONE),
      .BA_IN(BA_IN), .ADDR_ROW_IN(ADDR_ROW_IN), .ADDR_COL_IN(ADDR_COL_IN), .DATA_IN(DATA_IN),
      .WRITE_LENGTH(WRITE_LENGTH), .WRITE(WRITE), .READ(READ), .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- ddr_sdram responder ----------------
   bit resp_en = 1;
   int busy_len = 20;
   int busy_left = 0;
   int seen = 0;
   initial forever begin
      @(posedge clk); #1;
      if (!RST_N) begin
         BUSY = 0; busy_left = 0; seen = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) BUSY = 0;
      end else if (resp_en && (WRITE || READ)) begin
         seen++;
         if (seen == 3) begin
            BUSY = 1; busy_left = busy_len; seen = 0;
         end
      end else begin
         seen = 0;
      end
   end

   // ---------------- transaction-level model ----------------
   bit m_open = 0, m_acked = 0;
   int m_owner = 0, m_last = 1, m_age = 0;
   logic e_gnt0 = 0, e_gnt1 = 0, e_done0 = 0, e_done1 = 0, e_wr = 0, e_rd = 0, e_terr = 0;
   logic [1:0] e_ba = 0;
   logic [12:0] e_row = 0;
   logic [9:0] e_col = 0;
   logic [DW-1:0] e_data = 0;
   logic [3:0] e_len = 0;

   initial forever begin
      @(posedge clk or negedge RST_N);
      if (!RST_N) begin
         m_open = 0; m_acked = 0; m_owner = 0; m_last = 1; m_age = 0;
         {e_gnt0, e_gnt1, e_done0, e_done1, e_wr, e_rd, e_terr} = '0;
         e_ba = 0; e_row = 0; e_col = 0; e_data = 0; e_len = 0;
      end else begin
         e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
         if (!m_open) begin
            if (!BUSY && (P0_REQ || P1_REQ)) begin
               int w;
               if (P0_REQ && P1_REQ) w = 1 - m_last;
               else w = P1_REQ ? 1 : 0;
               if (w == 0) begin
                  e_ba = P0_BA; e_row = P0_ROW; e_col = P0_COL; e_data = P0_DATA; e_len = P0_LEN;
                  e_wr = P0_WR; e_gnt0 = 1;
               end else begin
                  e_ba = P1_BA; e_row = P1_ROW; e_col = P1_COL; e_data = P1_DATA; e_len = P1_LEN;
                  e_wr = P1_WR; e_gnt1 = 1;
               end
               e_rd = !e_wr;
               m_owner = w; m_last = w; m_open = 1; m_acked = 0; m_age = 0;
            end
         end else if (!m_acked) begin
            m_age++;
            if (BUSY) begin
               m_acked = 1; e_wr = 0; e_rd = 0;
            end else if (m_age >= TO) begin
               e_wr = 0; e_rd = 0; e_terr = 1; m_open = 0;
               if (m_owner == 0) e_done0 = 1; else e_done1 = 1;
            end
         end else if (!BUSY) begin
            m_open = 0;
            if (m_owner == 0) e_done0 = 1; else e_done1 = 1;
         end
      end
   end

   // ---------------- per-cycle compare and monitor ----------------
   int gnt_cnt[2], done_cnt[2];
   int gnt_q[$], ba_q[$];
   int wr_cycles = 0, rd_cycles = 0, rd_rises = 0, run = 0, max_run = 0, lowrun = 0, done_lag = 0;
   logic rd_prev = 0;

   initial forever begin
      @(negedge clk);
      chk("gnt", {P0_GNT, P1_GNT}, {e_gnt0, e_gnt1});
      chk("done", {P0_DONE, P1_DONE}, {e_done0, e_done1});
      chk("strobe", {WRITE, READ}, {e_wr, e_rd});
      chk("fields", {BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH}, {e_ba, e_row, e_col, e_len});
      chk("data", DATA_IN, e_data);
      chk("terr", TIMEOUT_ERR, e_terr);
      if (BUSY) lowrun = 0; else lowrun++;
      if (P0_GNT) begin gnt_cnt[0]++; gnt_q.push_back(0); ba_q.push_back(int'(BA_IN)); end
      if (P1_GNT) begin gnt_cnt[1]++; gnt_q.push_back(1); ba_q.push_back(int'(BA_IN)); end
      if (P0_DONE) begin done_cnt[0]++; done_lag = lowrun; end
      if (P1_DONE) begin done_cnt[1]++; done_lag = lowrun; end
      if (WRITE) wr_cycles++;
      if (READ) rd_cycles++;
      if (READ && !rd_prev) rd_rises++;
      rd_prev = READ;
      if (WRITE || READ) begin run++; if (run > max_run) max_run = run; end else run = 0;
   end

   task automatic clr();
      gnt_cnt[0] = 0; gnt_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
      gnt_q.delete(); ba_q.delete();
      wr_cycles = 0; rd_cycles = 0; rd_rises = 0; max_run = 0;
   endtask

   task automatic tick();
      @(posedge clk); #3;
   endtask

   function automatic logic sel(input int which);
      case (which)
         0: return P0_GNT;
         1: return P1_GNT;
         2: return P0_DONE;
         3: return P1_DONE;
         4: return P0_DONE | P1_DONE;
         default: return P0_GNT | P1_GNT;
      endcase
   endfunction

   task automatic wait_sig(input int which, input string nm);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (sel(which)) begin ok = 1; break; end
      end
      chk(nm, ok, 1'b1);
   endtask

   task automatic do_reset();
      RST_N = 0;
      repeat (2) tick();
      RST_N = 1;
      tick();
      clr();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1);
   end

   initial begin
      int v;
      int bad;
      int d0, d1;
      repeat (3) tick();
      chk("reset_ctl", {WRITE, READ, P0_GNT, P1_GNT, P0_DONE, P1_DONE, TIMEOUT_ERR}, 7'd0);
      chk("reset_fields", {BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH}, 29'd0);
      RST_N = 1;
      tick();
      clr();

      // single write on port 0
      P0_WR = 1; P0_BA = 2; P0_ROW = 13'h0005; P0_COL = 10'h010; P0_LEN = 15;
      P0_DATA = {16{16'hA5A5}};
      P0_REQ = 1;
      wait_sig(0, "t1_gnt");
      P0_REQ = 0;
      chk("t1_ba", BA_IN, 2'd2);
      chk("t1_col", ADDR_COL_IN, 10'h010);
      chk("t1_len", WRITE_LENGTH, 4'd15);
      chk("t1_write", WRITE, 1'b1);
      wait_sig(2, "t1_done");
      tick();
      chk("t1_write_cycles", wr_cycles, 3);
      chk("t1_read_cycles", rd_cycles, 0);
      chk("t1_gnt_pulses", gnt_cnt[0], 1);
      chk("t1_done_pulses", done_cnt[0], 1);
      chk("t1_done_lag", done_lag, 2);

      // contention from reset
      do_reset();
      busy_len = 5;
      P0_WR = 1; P0_BA = 1; P0_ROW = 13'h00AA; P0_COL = 10'h011; P0_LEN = 3;
      P1_WR = 0; P1_BA = 3; P1_ROW = 13'h0155; P1_COL = 10'h022; P1_LEN = 7;
      P1_DATA = {8{32'h1234_5678}};
      P0_REQ = 1; P1_REQ = 1;
      for (int k = 0; k < 4; k++) wait_sig(4, "t2_done");
      P0_REQ = 0; P1_REQ = 0;
      tick();
      chk("t2_count", gnt_q.size(), 4);
      v = 0;
      foreach (gnt_q[i]) v = v * 2 + gnt_q[i];
      chk("t2_order", v, 5);
      v = 0;
      foreach (ba_q[i]) v = v * 4 + ba_q[i];
      chk("t2_ba_order", v, 8'h77);

      // capture isolation on port 1
      P1_WR = 1; P1_ROW = 13'h0123;
      P1_REQ = 1;
      wait_sig(1, "t3_gnt");
      P1_ROW = 13'h1FFF; P1_REQ = 0;
      bad = 0;
      begin
         bit ok = 0;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (ADDR_ROW_IN !== 13'h0123) bad++;
            if (P1_DONE) begin ok = 1; break; end
         end
         chk("t3_done", ok, 1'b1);
      end
      chk("t3_row_changes", bad, 0);
      chk("t3_row_at_done", ADDR_ROW_IN, 13'h0123);

      // port 1 reads alone, three times
      tick();
      clr();
      P1_WR = 0; P1_BA = 1; P1_ROW = 13'h0042; P1_COL = 10'h3FF; P1_LEN = 0;
      for (int k = 0; k < 3; k++) begin
         P1_REQ = 1;
         wait_sig(1, "t4_gnt");
         P1_REQ = 0;
         wait_sig(3, "t4_done");
      end
      tick();
      chk("t4_read_pulses", rd_rises, 3);
      chk("t4_write_cycles", wr_cycles, 0);
      chk("t4_p1_grants", gnt_cnt[1], 3);
      chk("t4_p0_grants", gnt_cnt[0], 0);

      // issue timeout, then a normal request
      clr();
      resp_en = 0;
      P0_WR = 1; P0_REQ = 1;
      wait_sig(0, "t5_gnt");
      P0_REQ = 0;
      wait_sig(2, "t5_done");
      tick();
      chk("t5_strobe_width", max_run, 16);
      chk("t5_terr", TIMEOUT_ERR, 1'b1);
      chk("t5_done_pulses", done_cnt[0], 1);
      resp_en = 1;
      P0_WR = 0; P0_REQ = 1;
      wait_sig(0, "t5_gnt2");
      P0_REQ = 0;
      wait_sig(2, "t5_done2");
      tick();
      chk("t5_terr_sticky", TIMEOUT_ERR, 1'b1);
      chk("t5_done_pulses2", done_cnt[0], 2);
      chk("t5_read_pulses", rd_rises, 1);

      // reset while the controller is busy
      busy_len = 30;
      P0_WR = 1; P0_BA = 0; P0_REQ = 1;
      wait_sig(0, "t6_gnt");
      P0_REQ = 0;
      repeat (5) tick();
      chk("t6_in_wait", {BUSY, WRITE, READ}, 3'b100);
      d0 = done_cnt[0]; d1 = done_cnt[1];
      RST_N = 0;
      #1;
      chk("t6_rst_ctl", {WRITE, READ, P0_GNT, P1_GNT, P0_DONE, P1_DONE, TIMEOUT_ERR}, 7'd0);
      chk("t6_rst_fields", {BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH}, 29'd0);
      chk("t6_rst_data", DATA_IN, '0);
      repeat (3) tick();
      chk("t6_no_done", {done_cnt[0], done_cnt[1]}, {d0, d1});
      RST_N = 1;
      tick();
      P0_BA = 0; P1_BA = 3;
      P0_REQ = 1; P1_REQ = 1;
      wait_sig(5, "t6_gnt2");
      chk("t6_winner", {P0_GNT, P1_GNT}, 2'b10);
      P0_REQ = 0; P1_REQ = 0;
      wait_sig(4, "t6_done");
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
